instr_fetch: RTL and testbench

//  Front pipeline stage; feeds instr_decode through its `fetched` decoupled port ({pc, raw}).

---
 rtl/instr_fetch.sv | 133 +++++++++++++
 tb/tb_instr_fetch.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch front stage: holds the PC, issues word requests to imem, and
// queues tagged responses in a small FIFO towards decode. Flush redirects and drops stale data.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        fetched_valid_o,
    input  logic        fetched_ready_i,
    output logic [31:0] fetched_pc_o,
    output logic [31:0] fetched_raw_o,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_resp_valid_i,
    input  logic [31:0] imem_resp_data_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_CW = CW'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] tag_rd_q, tag_rd_d;
    logic [AW-1:0] tag_wr_q, tag_wr_d;

    logic [31:0] fifo_pc_q  [FIFO_DEPTH];
    logic [31:0] fifo_raw_q [FIFO_DEPTH];
    logic [31:0] tag_q      [FIFO_DEPTH];

    logic [CW:0] credit;
    logic        req_fire;
    logic        push;
    logic        pop;
    logic        unused_flush_lo;

    assign unused_flush_lo = ^flush_pc_i[1:0];

    // Credits cover both in-flight requests and queued entries, so a response always has a slot.
    assign credit           = {1'b0, inflight_q} + {1'b0, occ_q};
    assign imem_req_valid_o = !rst && !flush_i && (credit < DEPTH_W);
    assign imem_req_addr_o  = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    assign fetched_valid_o = !rst && !flush_i && (occ_q != '0);
    assign fetched_pc_o    = fifo_pc_q[rd_ptr_q];
    assign fetched_raw_o   = fifo_raw_q[rd_ptr_q];
    assign pop             = fetched_valid_o && fetched_ready_i;

    assign push = imem_resp_valid_i && !flush_i && (discard_q == '0);

    always_comb begin
        // NOTE: every next-state value gets a default first so no latch can be inferred.
        pc_d       = pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_resp_valid_i);
        discard_d  = discard_q;
        occ_d      = occ_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;

        if (flush_i) begin
            // Every request still outstanding after this cycle belongs to the old stream.
            pc_d      = {flush_pc_i[31:2], 2'b00};
            discard_d = inflight_q - CW'(imem_resp_valid_i);
            occ_d     = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            tag_rd_d  = '0;
            tag_wr_d  = '0;
        end else begin
            if (req_fire) begin
                pc_d     = pc_q + 32'd4;
                tag_wr_d = tag_wr_q + AW'(1);
            end
            if (imem_resp_valid_i && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            occ_d    = occ_q + CW'(push) - CW'(pop);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            wr_ptr_d = wr_ptr_q + AW'(push);
            tag_rd_d = tag_rd_q + AW'(push);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            occ_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            tag_rd_q   <= '0;
            tag_wr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            occ_q      <= occ_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
        end
    end

    // NOTE: storage arrays carry no reset; the pointers and counters alone decide validity.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_q[tag_wr_q] <= pc_q;
        end
        if (push) begin
            fifo_pc_q[wr_ptr_q]  <= tag_q[tag_rd_q];
            fifo_raw_q[wr_ptr_q] <= imem_resp_data_i;
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (occ_q == DEPTH_CW)));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized bench for instr_fetch: a latency-queue memory model plus an
// expected-PC scoreboard for both the request stream and the fetched stream.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetched_valid;
    logic        fready = 1'b0;
    logic [31:0] fetched_pc;
    logic [31:0] fetched_raw;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        imem_req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;

    instr_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .fetched_valid_o   (fetched_valid),
        .fetched_ready_i   (fready),
        .fetched_pc_o      (fetched_pc),
        .fetched_raw_o     (fetched_raw),
        .flush_i           (flush),
        .flush_pc_i        (flush_pc),
        .imem_req_valid_o  (imem_req_valid),
        .imem_req_ready_i  (req_ready),
        .imem_req_addr_o   (imem_req_addr),
        .imem_resp_valid_i (resp_valid),
        .imem_resp_data_i  (resp_data)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          last_due = 0;
    int          n_fetch = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_req = RESET_PC;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] fetch_log[$];
    logic [31:0] req_log[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        obs_req_valid, obs_fv;
    logic [31:0] obs_req_addr, obs_fpc, obs_fraw;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_5678;
    endfunction

    // One clock cycle: starts and ends at a negedge, samples 1ns after inputs are driven.
    task automatic tick();
        int due;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            resp_valid = 1'b1;
            resp_data  = memf(pend_addr[0]);
        end else begin
            resp_valid = 1'b0;
            resp_data  = '0;
        end
        #1;
        obs_req_valid = imem_req_valid;
        obs_req_addr  = imem_req_addr;
        obs_fv        = fetched_valid;
        obs_fpc       = fetched_pc;
        obs_fraw      = fetched_raw;
        if (prev_stall && !flush) begin
            checks++;
            if (obs_req_valid !== 1'b1 || obs_req_addr !== prev_addr) begin
                errors++;
                $display("FAIL req_hold: got valid=%b addr=%h required valid=1 addr=%h",
                         obs_req_valid, obs_req_addr, prev_addr);
            end
        end
        if (flush) begin
            checks++;
            if (obs_req_valid !== 1'b0 || obs_fv !== 1'b0) begin
                errors++;
                $display("FAIL flush_quiet: got req_valid=%b fetched_valid=%b required 0 0",
                         obs_req_valid, obs_fv);
            end
            exp_pc  = {flush_pc[31:2], 2'b00};
            exp_req = {flush_pc[31:2], 2'b00};
        end else begin
            if (obs_req_valid && req_ready) begin
                checks++;
                if (obs_req_addr !== exp_req) begin
                    errors++;
                    $display("FAIL req_addr: got %h required %h", obs_req_addr, exp_req);
                end
                req_log.push_back(obs_req_addr);
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend_addr.push_back(obs_req_addr);
                pend_due.push_back(due);
                exp_req = exp_req + 32'd4;
            end
            if (obs_fv && fready) begin
                checks++;
                if (obs_fpc !== exp_pc || obs_fraw !== memf(exp_pc)) begin
                    errors++;
                    $display("FAIL fetched: got pc=%h raw=%h required pc=%h raw=%h",
                             obs_fpc, obs_fraw, exp_pc, memf(exp_pc));
                end
                fetch_log.push_back(obs_fpc);
                exp_pc = exp_pc + 32'd4;
                n_fetch++;
            end
        end
        if (resp_valid) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        prev_stall = obs_req_valid && !req_ready && !flush;
        prev_addr  = obs_req_addr;
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        flush = 1'b0;
        req_ready = 1'b0;
        fready = 1'b1;
        repeat (8) tick();
    endtask

    task automatic check_pair(input string name, input logic [31:0] q[$], input int base,
                              input logic [31:0] a0, input logic [31:0] a1);
        checks++;
        if (q.size() < base + 2) begin
            errors++;
            $display("FAIL %s: got %0d entries required at least %0d", name, q.size(), base + 2);
        end else if (q[base] !== a0 || q[base+1] !== a1) begin
            errors++;
            $display("FAIL %s: got %h %h required %h %h", name, q[base], q[base+1], a0, a1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        req_ready = 1'b0;
        fready = 1'b0;
        resp_valid = 1'b0;
        resp_data = '0;
        pend_addr.delete();
        pend_due.delete();
        prev_stall = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || fetched_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_quiet: got req_valid=%b fetched_valid=%b required 0 0",
                     imem_req_valid, fetched_valid);
        end
        repeat (2) @(negedge clk);
        req_ready = 1'b1;
        fready = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || fetched_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got req_valid=%b fetched_valid=%b required 0 0",
                     imem_req_valid, fetched_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_pc = RESET_PC;
        exp_req = RESET_PC;
        cyc = 0;
        last_due = 0;
        lat = 1;
        fetch_log.delete();
        req_log.delete();
        tick();
        checks++;
        if (obs_req_valid !== 1'b1 || obs_req_addr !== RESET_PC) begin
            errors++;
            $display("FAIL first_req: got valid=%b addr=%h required valid=1 addr=%h",
                     obs_req_valid, obs_req_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        tick();
        checks++;
        if (obs_fv !== 1'b0) begin
            errors++;
            $display("FAIL early_valid: got %b required 0", obs_fv);
        end
        tick();
        checks++;
        if (obs_fv !== 1'b1 || obs_fpc !== RESET_PC) begin
            errors++;
            $display("FAIL first_fetch: got valid=%b pc=%h required valid=1 pc=%h",
                     obs_fv, obs_fpc, RESET_PC);
        end
        repeat (16) tick();
        check_pair("stream_head", fetch_log, 0, 32'h8000_0000, 32'h8000_0004);
        check_pair("stream_next", fetch_log, 2, 32'h8000_0008, 32'h8000_000C);
    endtask

    task automatic test_backpressure();
        int          n0;
        logic [31:0] first;
        drain();
        first = exp_req;
        n0 = req_log.size();
        req_ready = 1'b1;
        fready = 1'b0;
        lat = 1;
        repeat (10) tick();
        checks++;
        if (req_log.size() - n0 != DEPTH) begin
            errors++;
            $display("FAIL bp_issue: got %0d requests required %0d", req_log.size() - n0, DEPTH);
        end
        checks++;
        if (obs_req_valid !== 1'b0 || obs_fv !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: got req_valid=%b fetched_valid=%b required 0 1",
                     obs_req_valid, obs_fv);
        end
        fetch_log.delete();
        fready = 1'b1;
        repeat (10) tick();
        check_pair("bp_resume", fetch_log, 0, first, first + 32'd4);
    endtask

    task automatic test_flush_inflight();
        int n0;
        drain();
        lat = 4;
        n0 = req_log.size();
        req_ready = 1'b1;
        repeat (2) tick();
        checks++;
        if (req_log.size() - n0 != 2) begin
            errors++;
            $display("FAIL fl_setup: got %0d in flight required 2", req_log.size() - n0);
        end
        req_ready = 1'b0;
        flush = 1'b1;
        flush_pc = 32'h0000_1003;
        tick();
        flush = 1'b0;
        req_ready = 1'b1;
        lat = 1;
        fetch_log.delete();
        n0 = req_log.size();
        repeat (20) tick();
        check_pair("fl_req", req_log, n0, 32'h0000_1000, 32'h0000_1004);
        check_pair("fl_fetch", fetch_log, 0, 32'h0000_1000, 32'h0000_1004);
    endtask

    task automatic test_flush_with_resp();
        int n0;
        drain();
        lat = 2;
        req_ready = 1'b1;
        repeat (2) tick();
        checks++;
        if (pend_addr.size() != 2 || pend_due[0] != cyc) begin
            errors++;
            $display("FAIL fr_setup: got %0d pending required 2 with one due now", pend_addr.size());
        end
        flush = 1'b1;
        flush_pc = 32'h0000_2000;
        tick();
        flush = 1'b0;
        lat = 1;
        fetch_log.delete();
        n0 = req_log.size();
        repeat (15) tick();
        check_pair("fr_req", req_log, n0, 32'h0000_2000, 32'h0000_2004);
        check_pair("fr_fetch", fetch_log, 0, 32'h0000_2000, 32'h0000_2004);
    endtask

    task automatic test_wrap();
        int n0;
        req_ready = 1'b1;
        fready = 1'b1;
        lat = 1;
        flush = 1'b1;
        flush_pc = 32'hFFFF_FFFE;
        tick();
        flush = 1'b0;
        fetch_log.delete();
        n0 = req_log.size();
        repeat (20) tick();
        check_pair("wrap_req", req_log, n0, 32'hFFFF_FFFC, 32'h0000_0000);
        check_pair("wrap_fetch", fetch_log, 0, 32'hFFFF_FFFC, 32'h0000_0000);
    endtask

    task automatic test_random();
        int n0;
        n0 = n_fetch;
        for (int i = 0; i < 10000; i++) begin
            req_ready = ($urandom_range(0, 9) < 7);
            fready    = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 99) < 2);
            flush_pc  = $urandom();
            lat       = $urandom_range(1, 4);
            tick();
        end
        flush = 1'b0;
        checks++;
        if (n_fetch - n0 < 1000) begin
            errors++;
            $display("FAIL rand_progress: got %0d fetches required at least 1000", n_fetch - n0);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_inflight();
        test_flush_with_resp();
        test_wrap();
        test_random();
        test_reset();
        test_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
